// File: rtl/alu_cdb.sv
// alu_cdb: per-unit combinational RV32I ALUs broadcasting onto a tag-indexed, registered common data bus.
module alu_cdb #(
  parameter int NUM_UNITS = 4,
  parameter int NUM_TAGS  = 8,
  parameter int XLEN      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_UNITS-1:0]                 exec,
  input  logic [NUM_UNITS-1:0][6:0]            opcode,
  input  logic [NUM_UNITS-1:0][2:0]            funct3,
  input  logic [NUM_UNITS-1:0][6:0]            funct7,
  input  logic [NUM_UNITS-1:0][XLEN-1:0]       src1_data,
  input  logic [NUM_UNITS-1:0][XLEN-1:0]       src2_data,
  input  logic [NUM_UNITS-1:0][$clog2(NUM_TAGS)-1:0] tag,
  output logic [NUM_UNITS-1:0][XLEN-1:0]       alu_result,
  output logic [NUM_TAGS-1:0]                  cdb_enable,
  output logic [NUM_TAGS-1:0][XLEN-1:0]        cdb_data
);
  localparam int TW = $clog2(NUM_TAGS);
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LUI = 7'b0110111;
  logic [NUM_TAGS-1:0][XLEN-1:0] r_cdb_data, w_win;
  function automatic logic [XLEN-1:0] alu(input logic [6:0] op, input logic [2:0] f3, input logic alt,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  r = (op == OP && alt) ? a - b : a + b;
      3'b001:  r = a << sh;
      3'b010:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      3'b011:  r = {{(XLEN-1){1'b0}}, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? XLEN'($signed(a) >>> sh) : a >> sh;
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return (op == LUI) ? b : (op == OP || op == OP_IMM) ? r : a + b;
  endfunction
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++)
      alu_result[u] = alu(opcode[u], funct3[u], funct7[u][5], src1_data[u], src2_data[u]);
  end
  // Ascending scan lets the highest-index matching unit win each tag.
  always_comb begin
    cdb_enable = '0;
    w_win      = '0;
    for (int t = 0; t < NUM_TAGS; t++)
      for (int u = 0; u < NUM_UNITS; u++)
        if (exec[u] && tag[u] == TW'(t)) begin
          cdb_enable[t] = 1'b1;
          w_win[t]      = alu_result[u];
        end
  end
  always_ff @(posedge clk) begin
    if (rst) r_cdb_data <= '0;
    else
      for (int t = 0; t < NUM_TAGS; t++)
        if (cdb_enable[t]) r_cdb_data[t] <= w_win[t];
  end
  assign cdb_data = r_cdb_data;
endmodule

// File: tb/tb_alu_cdb.sv
// tb_alu_cdb: directed checks of the ALU decode and CDB write/priority/hold/reset behaviour.
module tb_alu_cdb;
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LUI = 7'b0110111;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0]        exec = '0;
  logic [3:0][6:0]   opcode = '0, funct7 = '0;
  logic [3:0][2:0]   funct3 = '0, tag = '0;
  logic [3:0][31:0]  src1_data = '0, src2_data = '0;
  logic [3:0][31:0]  alu_result;
  logic [7:0]        cdb_enable;
  logic [7:0][31:0]  cdb_data;
  int passed = 0, total = 0;

  alu_cdb dut (
    .clk(clk), .rst(rst), .exec(exec), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .src1_data(src1_data), .src2_data(src2_data), .tag(tag),
    .alu_result(alu_result), .cdb_enable(cdb_enable), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", nm, obs, exp);
  endtask

  task automatic set_unit(input int u, input logic e, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] tg);
    exec[u] = e; opcode[u] = op; funct3[u] = f3; funct7[u] = f7;
    src1_data[u] = a; src2_data[u] = b; tag[u] = tg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_enable", 32'(cdb_enable), 32'h0);
    for (int t = 0; t < 8; t++) chk($sformatf("reset_data%0d", t), cdb_data[t], 32'h0);

    // preload tag 1 with a nonzero value so the later zero write is observable
    set_unit(0, 1, 7'h00, 3'b000, 7'h00, 32'h50, 32'h5, 3'd1);
    step();
    exec = '0;
    chk("preload_tag1", cdb_data[1], 32'h55);

    set_unit(0, 1, OP, 3'b111, 7'h00, 32'hFFFF0000, 32'h0, 3'd1);
    #1;
    chk("and_result", alu_result[0], 32'h0);
    chk("and_enable", 32'(cdb_enable), 32'h02);
    chk("and_latency_old", cdb_data[1], 32'h55);
    step();
    exec = '0;
    chk("and_write", cdb_data[1], 32'h0);
    chk("and_other0", cdb_data[0], 32'h0);

    // OP-IMM ADD ignores funct7[5]
    set_unit(0, 1, OP_IMM, 3'b000, 7'h20, 32'h0, 32'd11, 3'd3);
    set_unit(1, 1, OP_IMM, 3'b000, 7'h20, 32'h0, 32'd12, 3'd4);
    set_unit(2, 1, OP_IMM, 3'b000, 7'h20, 32'h0, 32'd13, 3'd5);
    #1;
    chk("multi_enable", 32'(cdb_enable), 32'h38);
    step();
    exec = '0;
    chk("multi_tag3", cdb_data[3], 32'd11);
    chk("multi_tag4", cdb_data[4], 32'd12);
    chk("multi_tag5", cdb_data[5], 32'd13);

    set_unit(1, 1, OP, 3'b000, 7'h20, 32'd5, 32'd7, 3'd2);
    set_unit(3, 1, OP, 3'b000, 7'h00, 32'd1, 32'd1, 3'd2);
    #1;
    chk("prio_enable", 32'(cdb_enable), 32'h04);
    chk("sub_result", alu_result[1], 32'hFFFFFFFE);
    step();
    chk("prio_unit3_wins", cdb_data[2], 32'd2);
    exec[3] = 1'b0;
    step();
    exec = '0;
    chk("prio_unit1_only", cdb_data[2], 32'hFFFFFFFE);
    chk("prio_tag1_held", cdb_data[1], 32'h0);

    // combinational decode, no exec
    set_unit(0, 0, OP_IMM, 3'b101, 7'h20, 32'h80000000, 32'd4, 3'd0);
    set_unit(1, 0, OP, 3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 3'd0);
    set_unit(2, 0, OP, 3'b010, 7'h00, 32'd1, 32'hFFFFFFFF, 3'd0);
    set_unit(3, 0, LUI, 3'b000, 7'h00, 32'h12345678, 32'hABCDE000, 3'd0);
    #1;
    chk("srai", alu_result[0], 32'hF8000000);
    chk("sltu", alu_result[1], 32'd1);
    chk("slt", alu_result[2], 32'd0);
    chk("lui", alu_result[3], 32'hABCDE000);
    chk("idle_enable", 32'(cdb_enable), 32'h0);
    set_unit(0, 0, OP_IMM, 3'b101, 7'h00, 32'h80000000, 32'd4, 3'd0);
    set_unit(1, 0, OP, 3'b001, 7'h00, 32'd1, 32'h21, 3'd0);
    set_unit(2, 0, OP, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 3'd0);
    set_unit(3, 0, OP, 3'b110, 7'h00, 32'hF0F0F0F0, 32'h0F000000, 3'd0);
    #1;
    chk("srli", alu_result[0], 32'h08000000);
    chk("sll_mask", alu_result[1], 32'd2);
    chk("xor", alu_result[2], 32'h0FF00FF0);
    chk("or", alu_result[3], 32'hFFF0F0F0);
    set_unit(0, 0, OP, 3'b101, 7'h20, 32'h80000000, 32'd31, 3'd0);
    set_unit(1, 0, 7'b1100011, 3'b111, 7'h20, 32'hFFFFFFFF, 32'd3, 3'd0);
    #1;
    chk("sra_op", alu_result[0], 32'hFFFFFFFF);
    chk("other_add", alu_result[1], 32'd2);

    set_unit(2, 1, LUI, 3'b000, 7'h00, 32'h0, 32'h600D600D, 3'd6);
    step();
    exec = '0;
    step(); step(); step();
    chk("hold_tag6", cdb_data[6], 32'h600D600D);
    chk("hold_tag3", cdb_data[3], 32'd11);

    set_unit(0, 1, LUI, 3'b000, 7'h00, 32'h0, 32'hDEADBEEF, 3'd7);
    rst = 1'b1;
    #1;
    chk("rst_comb_enable", 32'(cdb_enable), 32'h80);
    chk("rst_comb_result", alu_result[0], 32'hDEADBEEF);
    step();
    chk("rst_clear_tag6", cdb_data[6], 32'h0);
    chk("rst_no_write_tag7", cdb_data[7], 32'h0);
    chk("rst_clear_tag2", cdb_data[2], 32'h0);
    rst = 1'b0;
    step();
    exec = '0;
    chk("post_rst_write", cdb_data[7], 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
